// File: rtl/uart_cmd_ctrl_if.sv
// rtl/uart_cmd_ctrl_if.sv - UART byte stream, TX handshake and register-bank signals of uart_cmd_ctrl
interface uart_cmd_ctrl_if;
  logic        i_RX_DV;
  logic [7:0]  i_RX_Byte;
  logic        i_TX_Active;
  logic        o_TX_DV;
  logic [7:0]  o_TX_Byte;
  logic [31:0] o_Regs;
  logic [3:0]  o_Wr_Strobe;
  logic        o_Frame_Err;
  logic        o_Busy;

  modport master (
    output i_RX_DV, i_RX_Byte, i_TX_Active,
    input  o_TX_DV, o_TX_Byte, o_Regs, o_Wr_Strobe, o_Frame_Err, o_Busy
  );

  modport slave (
    input  i_RX_DV, i_RX_Byte, i_TX_Active,
    output o_TX_DV, o_TX_Byte, o_Regs, o_Wr_Strobe, o_Frame_Err, o_Busy
  );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// rtl/uart_cmd_ctrl.sv - SYNC/CMD/DATA/CHK frame parser driving a 4 x 8-bit register bank
// Optional inter-byte timeout enabled by defining UART_CMD_TIMEOUT_EN.
module uart_cmd_ctrl #(
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         TIMEOUT_CLKS = 25000
) (
  input logic            i_Clk,
  input logic            i_Rst,
  uart_cmd_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_DATA, ST_CHK, ST_EXEC, ST_RESP
  } state_t;

  state_t      state;
  logic [7:0]  cmd_q;
  logic [7:0]  data_q;
  logic [31:0] regs_q;
  logic [7:0]  tx_byte_q;
  logic        tx_dv_q;
  logic [3:0]  strobe_q;
  logic        err_q;
  logic [7:0]  chk_calc;

  if (TIMEOUT_CLKS < 2 || TIMEOUT_CLKS > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CLKS must lie in 2..65535");
  end

  assign chk_calc = SYNC_BYTE + cmd_q + data_q;

`ifdef UART_CMD_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CLKS - 1);
  logic [15:0] idle_cnt;
  logic        waiting;
  assign waiting = (state == ST_CMD) || (state == ST_DATA) || (state == ST_CHK);
`endif

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state     <= ST_IDLE;
      cmd_q     <= '0;
      data_q    <= '0;
      regs_q    <= '0;
      tx_byte_q <= '0;
      tx_dv_q   <= 1'b0;
      strobe_q  <= '0;
      err_q     <= 1'b0;
`ifdef UART_CMD_TIMEOUT_EN
      idle_cnt  <= '0;
`endif
    end else begin
      tx_dv_q  <= 1'b0;
      strobe_q <= '0;
      err_q    <= 1'b0;
      unique case (state)
        ST_IDLE: if (bus.i_RX_DV && bus.i_RX_Byte == SYNC_BYTE) state <= ST_CMD;
        ST_CMD: if (bus.i_RX_DV) begin
          cmd_q <= bus.i_RX_Byte;
          state <= ST_DATA;
        end
        ST_DATA: if (bus.i_RX_DV) begin
          data_q <= bus.i_RX_Byte;
          state  <= ST_CHK;
        end
        ST_CHK: if (bus.i_RX_DV) begin
          if (bus.i_RX_Byte == chk_calc) begin
            state <= ST_EXEC;
          end else begin
            err_q <= 1'b1;
            state <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          state <= ST_IDLE;
          unique case (cmd_q[7:6])
            2'b00: begin
              regs_q[{cmd_q[1:0], 3'b000} +: 8] <= data_q;
              strobe_q <= 4'b0001 << cmd_q[1:0];
            end
            2'b01: state <= ST_RESP;
            2'b10: begin
              regs_q   <= '0;
              strobe_q <= 4'hF;
            end
            default: err_q <= 1'b1;
          endcase
        end
        // The host waits for the reply, so RESP never gives up on a busy transmitter.
        ST_RESP: if (!bus.i_TX_Active) begin
          tx_dv_q   <= 1'b1;
          tx_byte_q <= regs_q[{cmd_q[1:0], 3'b000} +: 8];
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
`ifdef UART_CMD_TIMEOUT_EN
      // A byte arriving on the expiry cycle takes priority over the timeout.
      if (!waiting || bus.i_RX_DV) begin
        idle_cnt <= '0;
      end else if (idle_cnt == TIMEOUT_LAST) begin
        idle_cnt <= '0;
        err_q    <= 1'b1;
        state    <= ST_IDLE;
      end else begin
        idle_cnt <= idle_cnt + 16'd1;
      end
`endif
    end
  end

  assign bus.o_Regs      = regs_q;
  assign bus.o_TX_DV     = tx_dv_q;
  assign bus.o_TX_Byte   = tx_byte_q;
  assign bus.o_Wr_Strobe = strobe_q;
  assign bus.o_Frame_Err = err_q;
  assign bus.o_Busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb/tb_uart_cmd_ctrl.sv - scoreboard bench for uart_cmd_ctrl frame parsing, reads, errors and timeout
module tb_uart_cmd_ctrl;
  localparam int T = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_cmd_ctrl_if bus();
  uart_cmd_ctrl #(.SYNC_BYTE(8'hA5), .TIMEOUT_CLKS(T)) dut (.i_Clk(clk), .i_Rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;
  logic [35:0] obs_wr[$];
  logic [35:0] exp_wr[$];
  logic [8:0]  obs_tx[$];
  logic [7:0]  exp_tx[$];
  int obs_err = 0;
  int exp_err;
  int e0;
  logic [31:0] tb_regs;
  logic [35:0] got_wr;
  logic [35:0] want_wr;
  logic [8:0]  got_tx;
  logic [7:0]  want_tx;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.o_Wr_Strobe != 4'h0) obs_wr.push_back({bus.o_Wr_Strobe, bus.o_Regs});
      if (bus.o_TX_DV) obs_tx.push_back({bus.i_TX_Active, bus.o_TX_Byte});
      if (bus.o_Frame_Err) obs_err++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.i_RX_DV   = 1'b1;
    bus.i_RX_Byte = b;
    @(posedge clk);
    #1;
    bus.i_RX_DV   = 1'b0;
  endtask

  task automatic sb_clear();
    obs_wr.delete();
    exp_wr.delete();
    obs_tx.delete();
    exp_tx.delete();
    exp_err = 0;
    e0 = obs_err;
  endtask

  // Drives one frame and predicts its effect from the frame contents alone.
  task automatic send_frame(input logic [7:0] cmd, input logic [7:0] data,
                            input logic [7:0] chk, input int gap);
    logic [7:0] sum;
    logic [3:0] s;
    sum = 8'hA5 + cmd + data;
    if (chk != sum) begin
      exp_err++;
    end else begin
      case (cmd[7:6])
        2'b00: begin
          tb_regs[{cmd[1:0], 3'b000} +: 8] = data;
          s = 4'b0001 << cmd[1:0];
          exp_wr.push_back({s, tb_regs});
        end
        2'b01: exp_tx.push_back(tb_regs[{cmd[1:0], 3'b000} +: 8]);
        2'b10: begin
          tb_regs = '0;
          exp_wr.push_back({4'hF, 32'h0});
        end
        default: exp_err++;
      endcase
    end
    send_byte(8'hA5);
    send_byte(cmd);
    send_byte(data);
    send_byte(chk);
    idle(gap);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_RX_DV = 1'b0;
    bus.i_RX_Byte = 8'h00;
    bus.i_TX_Active = 1'b0;
    tb_regs = '0;
    idle(3);
    n_cmp++; if (bus.o_Regs !== 32'h0) begin n_bad++; $display("FAIL reset_regs: got %h want 0", bus.o_Regs); end
    n_cmp++; if (bus.o_TX_Byte !== 8'h0) begin n_bad++; $display("FAIL reset_tx_byte: got %h want 0", bus.o_TX_Byte); end
    n_cmp++; if (bus.o_TX_DV !== 1'b0) begin n_bad++; $display("FAIL reset_tx_dv: got %b want 0", bus.o_TX_DV); end
    n_cmp++; if (bus.o_Wr_Strobe !== 4'h0) begin n_bad++; $display("FAIL reset_strobe: got %h want 0", bus.o_Wr_Strobe); end
    n_cmp++; if (bus.o_Frame_Err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", bus.o_Frame_Err); end
    n_cmp++; if (bus.o_Busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.o_Busy); end
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_write();
    sb_clear();
    send_frame(8'h02, 8'h3C, 8'hE3, 2);
    idle(3);
    n_cmp++; if (obs_wr.size() !== 1) begin n_bad++; $display("FAIL write_count: got %0d want 1", obs_wr.size()); end
    if (obs_wr.size() > 0 && exp_wr.size() > 0) begin
      got_wr = obs_wr.pop_front(); want_wr = exp_wr.pop_front();
      n_cmp++; if (got_wr !== want_wr) begin n_bad++; $display("FAIL write_event: got %h want %h", got_wr, want_wr); end
    end
    n_cmp++; if (bus.o_Regs[23:16] !== 8'h3C) begin n_bad++; $display("FAIL write_reg2: got %h want 3c", bus.o_Regs[23:16]); end
    n_cmp++; if (obs_tx.size() !== 0) begin n_bad++; $display("FAIL write_no_tx: got %0d want 0", obs_tx.size()); end
    n_cmp++; if (obs_err - e0 !== exp_err) begin n_bad++; $display("FAIL write_no_err: got %0d want %0d", obs_err - e0, exp_err); end
  endtask

  task automatic test_read();
    sb_clear();
    bus.i_TX_Active = 1'b1;
    send_frame(8'h42, 8'h00, 8'hE7, 0);
    idle(50);
    n_cmp++; if (obs_tx.size() !== 0) begin n_bad++; $display("FAIL read_held: got %0d want 0", obs_tx.size()); end
    n_cmp++; if (bus.o_Busy !== 1'b1) begin n_bad++; $display("FAIL read_busy: got %b want 1", bus.o_Busy); end
    bus.i_TX_Active = 1'b0;
    for (int i = 0; i < 20 && obs_tx.size() == 0; i++) idle(1);
    idle(2);
    n_cmp++; if (obs_tx.size() !== 1) begin n_bad++; $display("FAIL read_count: got %0d want 1", obs_tx.size()); end
    if (obs_tx.size() > 0 && exp_tx.size() > 0) begin
      got_tx = obs_tx.pop_front(); want_tx = exp_tx.pop_front();
      n_cmp++; if (got_tx !== {1'b0, want_tx}) begin n_bad++; $display("FAIL read_event: got %h want %h", got_tx, {1'b0, want_tx}); end
    end
    n_cmp++; if (bus.o_TX_Byte !== 8'h3C) begin n_bad++; $display("FAIL read_byte_hold: got %h want 3c", bus.o_TX_Byte); end
    n_cmp++; if (bus.o_Busy !== 1'b0) begin n_bad++; $display("FAIL read_idle: got %b want 0", bus.o_Busy); end
  endtask

  task automatic test_bad_chk();
    sb_clear();
    send_frame(8'h01, 8'h55, 8'h00, 3);
    n_cmp++; if (obs_err - e0 !== exp_err) begin n_bad++; $display("FAIL badchk_err: got %0d want %0d", obs_err - e0, exp_err); end
    n_cmp++; if (bus.o_Regs[15:8] !== tb_regs[15:8]) begin n_bad++; $display("FAIL badchk_reg1: got %h want %h", bus.o_Regs[15:8], tb_regs[15:8]); end
    n_cmp++; if (obs_wr.size() !== 0) begin n_bad++; $display("FAIL badchk_no_wr: got %0d want 0", obs_wr.size()); end
    send_frame(8'h01, 8'h55, 8'hFB, 3);
    if (obs_wr.size() > 0 && exp_wr.size() > 0) begin
      got_wr = obs_wr.pop_front(); want_wr = exp_wr.pop_front();
      n_cmp++; if (got_wr !== want_wr) begin n_bad++; $display("FAIL goodchk_event: got %h want %h", got_wr, want_wr); end
    end
    n_cmp++; if (bus.o_Regs[15:8] !== 8'h55) begin n_bad++; $display("FAIL goodchk_reg1: got %h want 55", bus.o_Regs[15:8]); end
  endtask

  task automatic test_clear_illegal();
    sb_clear();
    send_frame(8'h80, 8'h00, 8'h25, 3);
    n_cmp++; if (obs_wr.size() !== 1) begin n_bad++; $display("FAIL clear_count: got %0d want 1", obs_wr.size()); end
    if (obs_wr.size() > 0 && exp_wr.size() > 0) begin
      got_wr = obs_wr.pop_front(); want_wr = exp_wr.pop_front();
      n_cmp++; if (got_wr !== want_wr) begin n_bad++; $display("FAIL clear_event: got %h want %h", got_wr, want_wr); end
    end
    n_cmp++; if (bus.o_Regs !== 32'h0) begin n_bad++; $display("FAIL clear_regs: got %h want 0", bus.o_Regs); end
    send_frame(8'hC0, 8'h00, 8'h65, 3);
    n_cmp++; if (obs_err - e0 !== 1) begin n_bad++; $display("FAIL illegal_err: got %0d want 1", obs_err - e0); end
    n_cmp++; if (obs_wr.size() !== 0) begin n_bad++; $display("FAIL illegal_no_wr: got %0d want 0", obs_wr.size()); end
  endtask

  task automatic test_resync();
    sb_clear();
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h13);
    send_frame(8'h00, 8'h77, 8'h1C, 3);
    if (obs_wr.size() > 0 && exp_wr.size() > 0) begin
      got_wr = obs_wr.pop_front(); want_wr = exp_wr.pop_front();
      n_cmp++; if (got_wr !== want_wr) begin n_bad++; $display("FAIL resync_event: got %h want %h", got_wr, want_wr); end
    end
    n_cmp++; if (bus.o_Regs[7:0] !== 8'h77) begin n_bad++; $display("FAIL resync_reg0: got %h want 77", bus.o_Regs[7:0]); end
    n_cmp++; if (obs_err - e0 !== 0) begin n_bad++; $display("FAIL resync_no_err: got %0d want 0", obs_err - e0); end
    send_byte(8'hA5);
    send_byte(8'h01);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    tb_regs = '0;
    sb_clear();
    send_byte(8'h11);
    send_byte(8'hB7);
    idle(4);
    n_cmp++; if (bus.o_Regs !== 32'h0) begin n_bad++; $display("FAIL midreset_regs: got %h want 0", bus.o_Regs); end
    n_cmp++; if (obs_wr.size() !== 0) begin n_bad++; $display("FAIL midreset_no_wr: got %0d want 0", obs_wr.size()); end
    n_cmp++; if (bus.o_Busy !== 1'b0) begin n_bad++; $display("FAIL midreset_busy: got %b want 0", bus.o_Busy); end
  endtask

  // Each next byte lands exactly on the would-be expiry edge, so it must be accepted.
  task automatic test_timeout_boundary();
    sb_clear();
    send_byte(8'hA5); idle(T - 1);
    send_byte(8'h01); idle(T - 1);
    send_byte(8'h22); idle(T - 1);
    send_byte(8'hC8); idle(3);
    tb_regs[15:8] = 8'h22;
    n_cmp++; if (obs_wr.size() !== 1) begin n_bad++; $display("FAIL tmo_edge_count: got %0d want 1", obs_wr.size()); end
    if (obs_wr.size() > 0) begin
      got_wr = obs_wr.pop_front();
      n_cmp++; if (got_wr !== {4'b0010, tb_regs}) begin n_bad++; $display("FAIL tmo_edge_event: got %h want %h", got_wr, {4'b0010, tb_regs}); end
    end
    n_cmp++; if (obs_err - e0 !== 0) begin n_bad++; $display("FAIL tmo_edge_no_err: got %0d want 0", obs_err - e0); end
  endtask

  task automatic test_timeout();
    sb_clear();
    send_byte(8'hA5);
    send_byte(8'h01);
    idle(T + 4);
`ifdef UART_CMD_TIMEOUT_EN
    n_cmp++; if (obs_err - e0 !== 1) begin n_bad++; $display("FAIL tmo_err: got %0d want 1", obs_err - e0); end
    n_cmp++; if (bus.o_Busy !== 1'b0) begin n_bad++; $display("FAIL tmo_idle: got %b want 0", bus.o_Busy); end
    send_byte(8'h11);
    send_byte(8'hB7);
    idle(4);
    n_cmp++; if (bus.o_Regs[15:8] !== tb_regs[15:8]) begin n_bad++; $display("FAIL tmo_stale_bytes: got %h want %h", bus.o_Regs[15:8], tb_regs[15:8]); end
`else
    n_cmp++; if (obs_err - e0 !== 0) begin n_bad++; $display("FAIL notmo_err: got %0d want 0", obs_err - e0); end
    n_cmp++; if (bus.o_Busy !== 1'b1) begin n_bad++; $display("FAIL notmo_busy: got %b want 1", bus.o_Busy); end
    send_byte(8'h11);
    send_byte(8'hB7);
    idle(4);
    n_cmp++; if (bus.o_Regs[15:8] !== 8'h11) begin n_bad++; $display("FAIL notmo_reg1: got %h want 11", bus.o_Regs[15:8]); end
    tb_regs[15:8] = 8'h11;
`endif
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    logic [7:0] c;
    sb_clear();
    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom_range(0, 255));
      c = 8'(i);
      send_frame(c, d, 8'hA5 + c + d, 1);
    end
    send_frame(8'h42, 8'h00, 8'hE7, 0);
    idle(6);
    n_cmp++; if (obs_wr.size() !== 4) begin n_bad++; $display("FAIL b2b_wr_count: got %0d want 4", obs_wr.size()); end
    while (obs_wr.size() > 0 && exp_wr.size() > 0) begin
      got_wr = obs_wr.pop_front(); want_wr = exp_wr.pop_front();
      n_cmp++; if (got_wr !== want_wr) begin n_bad++; $display("FAIL b2b_wr_event: got %h want %h", got_wr, want_wr); end
    end
    n_cmp++; if (obs_tx.size() !== 1) begin n_bad++; $display("FAIL b2b_tx_count: got %0d want 1", obs_tx.size()); end
    if (obs_tx.size() > 0 && exp_tx.size() > 0) begin
      got_tx = obs_tx.pop_front(); want_tx = exp_tx.pop_front();
      n_cmp++; if (got_tx !== {1'b0, want_tx}) begin n_bad++; $display("FAIL b2b_tx_event: got %h want %h", got_tx, {1'b0, want_tx}); end
    end
    n_cmp++; if (bus.o_Regs !== tb_regs) begin n_bad++; $display("FAIL b2b_regs: got %h want %h", bus.o_Regs, tb_regs); end
    n_cmp++; if (obs_err - e0 !== 0) begin n_bad++; $display("FAIL b2b_no_err: got %0d want 0", obs_err - e0); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_bad_chk();
    test_clear_illegal();
    test_resync();
    test_timeout_boundary();
    test_timeout();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
